nem_ohmux_sel_driver: RTL and testbench

Sequencing controller that drives the one-hot select lines S[N_IN-1:0] of a NEM-relay one-hot inverting mux bank. It accepts path-select requests through a valid/ready handshake and applies them to the relays with break-before-make timing. Every relay is released and allowed to open mechanically before the new one is energised. It asserts `settled` once the new path has had its full pull-in time, so downstream logic knows when the mux outputs are valid. It sits between the configuration/routing logic and every instance of the relay mux family.

---
 rtl/nem_ohmux_sel_driver.sv | 127 ++++++++++++
 tb/tb_nem_ohmux_sel_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_sel_driver.sv
// rtl/nem_ohmux_sel_driver.sv - break-before-make sequencer for NEM-relay one-hot mux select lines
// Every select change opens the old relay for T_OFF cycles before energising the new one for T_ON.
module nem_ohmux_sel_driver #(
    parameter int N_IN  = 4,
    parameter int T_OFF = 4,
    parameter int T_ON  = 8,
    parameter int SW    = $clog2(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_off,
    input  logic [SW-1:0]   req_sel,
    output logic [N_IN-1:0] S,
    output logic            settled,
    output logic [SW-1:0]   cur_sel,
    output logic            cur_on
);

    localparam int CMAX = (T_OFF > T_ON) ? T_OFF : T_ON;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [N_IN-1:0] ONE = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAKE,
        ST_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SW-1:0]   r_cur_sel;
    logic [SW-1:0]   w_sel_nxt;
    logic            r_cur_on;
    logic            w_on_nxt;
    logic [N_IN-1:0] r_s;
    logic            r_settled;
    logic            r_ready;
    logic            w_accept;
    logic            w_off_req;
    logic [N_IN-1:0] w_s_nxt;

    assign w_accept  = req_valid & r_ready;
    // Out-of-range indices (non-power-of-2 N_IN) deselect rather than alias onto a real input.
    assign w_off_req = req_off | ({1'b0, req_sel} >= (SW+1)'(N_IN));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_cur_sel;
        w_on_nxt    = r_cur_on;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_off_req) begin
                    w_state_nxt = ST_MAKE;
                    w_cnt_nxt   = CW'(T_ON);
                    w_sel_nxt   = req_sel;
                    w_on_nxt    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    if (w_off_req) begin
                        w_state_nxt = ST_BREAK;
                        w_cnt_nxt   = CW'(T_OFF);
                        w_on_nxt    = 1'b0;
                    end else if (req_sel != r_cur_sel) begin
                        w_state_nxt = ST_BREAK;
                        w_cnt_nxt   = CW'(T_OFF);
                        w_sel_nxt   = req_sel;
                    end
                end
            end
            ST_BREAK: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = r_cur_on ? ST_MAKE : ST_IDLE;
                    w_cnt_nxt   = r_cur_on ? CW'(T_ON) : '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_MAKE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_s_nxt = ((w_state_nxt == ST_MAKE) || (w_state_nxt == ST_HOLD)) ? (ONE << w_sel_nxt) : '0;

    // Outputs are computed from the next state so they are true registers, not state decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cur_sel <= '0;
            r_cur_on  <= 1'b0;
            r_s       <= '0;
            r_settled <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_sel <= w_sel_nxt;
            r_cur_on  <= w_on_nxt;
            r_s       <= w_s_nxt;
            r_settled <= (w_state_nxt == ST_HOLD);
            r_ready   <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_IDLE);
        end
    end

    assign S         = r_s;
    assign settled   = r_settled;
    assign req_ready = r_ready;
    assign cur_sel   = r_cur_sel;
    assign cur_on    = r_cur_on;

endmodule

// File: tb/tb_nem_ohmux_sel_driver.sv
// tb/tb_nem_ohmux_sel_driver.sv - scoreboard bench for nem_ohmux_sel_driver
// Two instances run in turn: (N_IN=4,T_OFF=4,T_ON=8) and (N_IN=3,T_OFF=1,T_ON=1).
module tb_nem_ohmux_sel_driver;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       phase;
    logic       req_valid;
    logic       req_off;
    logic [1:0] req_sel;

    logic       rst_a, rst_b;
    logic       ready_a, ready_b, settled_a, settled_b, on_a, on_b;
    logic [3:0] s_a;
    logic [2:0] s_b;
    logic [1:0] sel_a, sel_b;

    assign rst_a = rst | phase;
    assign rst_b = rst | ~phase;

    nem_ohmux_sel_driver #(.N_IN(4), .T_OFF(4), .T_ON(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid & ~phase), .req_ready(ready_a),
        .req_off(req_off), .req_sel(req_sel), .S(s_a), .settled(settled_a),
        .cur_sel(sel_a), .cur_on(on_a)
    );

    nem_ohmux_sel_driver #(.N_IN(3), .T_OFF(1), .T_ON(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid & phase), .req_ready(ready_b),
        .req_off(req_off), .req_sel(req_sel), .S(s_b), .settled(settled_b),
        .cur_sel(sel_b), .cur_on(on_b)
    );

    wire [3:0] m_s       = phase ? {1'b0, s_b} : s_a;
    wire       m_settled = phase ? settled_b : settled_a;
    wire       m_ready   = phase ? ready_b : ready_a;
    wire       m_cur_on  = phase ? on_b : on_a;
    wire [1:0] m_cur_sel = phase ? sel_b : sel_a;

    typedef struct packed {
        logic [3:0] s;
        logic       settled;
        logic       ready;
        logic       on;
        logic [1:0] sel;
    } rec_t;

    int   n_in, t_off, t_on;
    rec_t exp_q[$];
    rec_t steady;
    rec_t cur_exp;
    bit   m_on;
    logic [1:0] m_sel;
    bit   m_exp_ready = 1'b0;
    bit   eff_off;
    int   acc_cnt = 0;
    bit   chk_en = 1'b0;
    logic [3:0] prev_s = '0;
    int   asserts = 0;
    int   fails = 0;

    function automatic rec_t mk(input logic [3:0] s, input logic st, input logic rdy,
                                input logic on, input logic [1:0] sel);
        rec_t r;
        r.s = s; r.settled = st; r.ready = rdy; r.on = on; r.sel = sel;
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] k);
        logic [3:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic push_n(input int n, input rec_t r);
        repeat (n) exp_q.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] expv);
        asserts++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Reference model: on each accepted request, lay out the expected per-cycle output timeline.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_on   = 1'b0;
            m_sel  = '0;
            steady = mk(4'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        end else if (req_valid && m_exp_ready) begin
            acc_cnt++;
            eff_off = req_off || (int'(req_sel) >= n_in);
            if (!m_on) begin
                if (!eff_off) begin
                    push_n(t_on, mk(onehot(req_sel), 1'b0, 1'b0, 1'b1, req_sel));
                    steady = mk(onehot(req_sel), 1'b1, 1'b1, 1'b1, req_sel);
                    m_on   = 1'b1;
                    m_sel  = req_sel;
                end
            end else if (eff_off) begin
                push_n(t_off, mk(4'b0, 1'b0, 1'b0, 1'b0, m_sel));
                steady = mk(4'b0, 1'b0, 1'b1, 1'b0, m_sel);
                m_on   = 1'b0;
            end else if (req_sel != m_sel) begin
                push_n(t_off, mk(4'b0, 1'b0, 1'b0, 1'b1, req_sel));
                push_n(t_on, mk(onehot(req_sel), 1'b0, 1'b0, 1'b1, req_sel));
                steady = mk(onehot(req_sel), 1'b1, 1'b1, 1'b1, req_sel);
                m_sel  = req_sel;
            end
        end
    end

    // Monitor: pops one expected cycle per clock, falling back to the steady state.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else                  cur_exp = steady;
            m_exp_ready = cur_exp.ready;
            chk("S", m_s, cur_exp.s);
            chk("settled", {3'b0, m_settled}, {3'b0, cur_exp.settled});
            chk("req_ready", {3'b0, m_ready}, {3'b0, cur_exp.ready});
            chk("cur_on", {3'b0, m_cur_on}, {3'b0, cur_exp.on});
            if (cur_exp.on) chk("cur_sel", {2'b0, m_cur_sel}, {2'b0, cur_exp.sel});
            chk("S_onehot", {3'b0, ($countones(m_s) <= 1)}, 4'd1);
            if (prev_s != 4'b0 && m_s != 4'b0)
                chk("S_no_direct_switch", m_s, prev_s);
            prev_s = m_s;
        end
    end

    task automatic do_req(input bit off, input logic [1:0] sel, input bit jitter);
        int n0;
        int waited;
        req_valid = 1'b1;
        req_off   = off;
        req_sel   = sel;
        n0        = acc_cnt;
        waited    = 0;
        while (acc_cnt == n0 && waited < 200) begin
            @(negedge clk);
            waited++;
            if (jitter && acc_cnt == n0) req_sel = 2'($urandom);
        end
        if (acc_cnt == n0) begin
            asserts++;
            fails++;
            $display("FAIL accept_timeout at %0t: got no accept expected accept within 200 cycles", $time);
        end
        req_valid = 1'b0;
    endtask

    task automatic random_reqs(input int n);
        for (int i = 0; i < n; i++) begin
            do_req(($urandom_range(0, 4) == 0), 2'($urandom), ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; phase = 1'b0; req_valid = 1'b0; req_off = 1'b0; req_sel = '0;
        n_in = 4; t_off = 4; t_on = 8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);

        do_req(1'b0, 2'd2, 1'b0);
        do_req(1'b0, 2'd0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0);
        do_req(1'b0, 2'd1, 1'b0);
        do_req(1'b0, 2'd3, 1'b0);
        do_req(1'b1, 2'd0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 2'd1, 1'b0);
        do_req(1'b0, 2'd2, 1'b1);
        random_reqs(40);
        repeat (20) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        phase = 1'b1; n_in = 3; t_off = 1; t_on = 1;
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 2'd0, 1'b0);
        do_req(1'b0, 2'd3, 1'b0);
        do_req(1'b0, 2'd2, 1'b0);
        do_req(1'b0, 2'd1, 1'b1);
        random_reqs(60);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
